// File: rtl/run_limit_stuffer.sv
// -----------------------------------------------------------------------------
// run_limit_stuffer
//
// Purpose:
//   Serial bit stuffer. Forwards a stream of data bits and forces a
//   complementary stuff bit after every MAX_RUN equal consecutive output bits,
//   so the line never shows a run longer than MAX_RUN. Stuff bits start a new
//   run of length 1 that later equal data bits extend. Run tracking lives in
//   the bit stream, not in time: idle gaps do not reset it, only sync_clear
//   (start of frame) or reset does.
//
// Parameters:
//   MAX_RUN  longest run of equal output bits before a stuff bit (2..15)
//   CNT_W    width of the saturating stuff-event counter
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   in_valid     in   upstream bit valid
//   in_bit       in   upstream data bit
//   in_ready     out  block accepts in_bit this cycle (combinational)
//   out_valid    out  out_bit valid (registered)
//   out_bit      out  serial line bit (registered)
//   out_ready    in   downstream consumes out_bit this cycle
//   out_stuffed  out  current out_bit is an inserted stuff bit
//   sync_clear   in   synchronous start-of-frame, clears run tracking
//   stuff_count  out  saturating count of inserted stuff bits
//   dbg_state    out  output-register FSM state (0 EMPTY, 1 DATA, 2 STUFF)
//   dbg_run_len  out  current run length of the output stream
//   dbg_pending  out  a stuff bit is owed in the next output slot
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid; out_valid never depends on
// out_ready. Once out_valid is high, out_bit and out_stuffed hold until the
// edge where out_ready is also high.
// -----------------------------------------------------------------------------
module run_limit_stuffer #(
    parameter int MAX_RUN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    input  logic             out_ready,
    output logic             out_stuffed,
    input  logic             sync_clear,
    output logic [CNT_W-1:0] stuff_count,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_run_len,
    output logic             dbg_pending
);

    // Output-register occupancy. pending_stuff is tracked separately: a stuff
    // bit can be owed while the register holds data or is empty.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam logic [3:0]       MAX_RUN_L = 4'(MAX_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state;
    logic       last_bit;
    logic [3:0] run_len;
    logic       pending_stuff;

    logic       loadable;
    logic       in_xfer;
    logic [3:0] next_run;

    // The output register can take a new bit when it is empty or its current
    // bit is being consumed this cycle.
    assign loadable = ~out_valid | out_ready;

    // reset gates in_ready so nothing is acknowledged while held in reset.
    assign in_ready = reset & loadable & ~pending_stuff & ~sync_clear;
    assign in_xfer  = in_valid & in_ready;

    // Run length after accepting in_bit. run_len==0 means no bit seen since
    // reset or frame start, so the first bit always starts a run of 1.
    always_comb begin
        next_run = 4'd1;
        if ((run_len != 4'd0) && (in_bit == last_bit)) begin
            next_run = run_len + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= EMPTY;
            out_valid     <= 1'b0;
            out_bit       <= 1'b0;
            out_stuffed   <= 1'b0;
            last_bit      <= 1'b0;
            run_len       <= 4'd0;
            pending_stuff <= 1'b0;
            stuff_count   <= '0;
        end else if (sync_clear) begin
            // Frame start wins over any load: an owed stuff bit is dropped and
            // the run restarts. The register still drains its current bit.
            run_len       <= 4'd0;
            pending_stuff <= 1'b0;
            if (loadable) begin
                out_valid <= 1'b0;
                state     <= EMPTY;
            end
        end else if (loadable) begin
            if (pending_stuff) begin
                // Stuff slot: complement of the run just completed; it begins
                // a fresh run of length 1.
                out_bit       <= ~last_bit;
                out_stuffed   <= 1'b1;
                out_valid     <= 1'b1;
                state         <= STUFF;
                last_bit      <= ~last_bit;
                run_len       <= 4'd1;
                pending_stuff <= 1'b0;
                if (stuff_count != CNT_MAX) begin
                    stuff_count <= stuff_count + CNT_W'(1);
                end
            end else if (in_xfer) begin
                out_bit       <= in_bit;
                out_stuffed   <= 1'b0;
                out_valid     <= 1'b1;
                state         <= DATA;
                last_bit      <= in_bit;
                run_len       <= next_run;
                // Owe a stuff bit the moment the run reaches the limit so it
                // takes the very next output slot.
                pending_stuff <= (next_run == MAX_RUN_L);
            end else begin
                out_valid <= 1'b0;
                state     <= EMPTY;
            end
        end
        // Not loadable: output register and tracking hold.
    end

    assign dbg_state   = state;
    assign dbg_run_len = run_len;
    assign dbg_pending = pending_stuff;

endmodule

// File: tb/tb_run_limit_stuffer.sv
// -----------------------------------------------------------------------------
// tb_run_limit_stuffer
//
// Directed bench for run_limit_stuffer (MAX_RUN=4, CNT_W=3 so saturation is
// reachable quickly). Inputs change 1 time unit after a rising edge; outputs
// are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_run_limit_stuffer;

    localparam int MAX_RUN = 4;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_ready;
    logic             out_stuffed;
    logic             sync_clear;
    logic [CNT_W-1:0] stuff_count;
    logic [1:0]       dbg_state;
    logic [3:0]       dbg_run_len;
    logic             dbg_pending;

    int checks   = 0;
    int failures = 0;

    // line monitor state
    int   mon_run  = 0;
    int   mon_max  = 0;
    logic mon_last = 1'b0;

    run_limit_stuffer #(
        .MAX_RUN (MAX_RUN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_ready   (out_ready),
        .out_stuffed (out_stuffed),
        .sync_clear  (sync_clear),
        .stuff_count (stuff_count),
        .dbg_state   (dbg_state),
        .dbg_run_len (dbg_run_len),
        .dbg_pending (dbg_pending)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- line monitor ----------------
    // Tracks runs of equal transferred output bits; restarts at frame start.
    always @(negedge clk) begin
        int nr;
        nr = mon_run;
        if (!reset) begin
            nr = 0;
        end else begin
            if (out_valid && out_ready) begin
                nr = (nr != 0 && out_bit == mon_last) ? nr + 1 : 1;
                mon_last <= out_bit;
                if (nr > mon_max) mon_max <= nr;
            end
            if (sync_clear) nr = 0;
        end
        mon_run <= nr;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check in_ready, clock, check output register.
    task automatic step(input string tag, input logic iv, input logic ib, input logic ordy,
                        input logic sc, input logic exp_rdy, input logic exp_ov,
                        input logic exp_ob, input logic exp_os);
        in_valid   = iv;
        in_bit     = ib;
        out_ready  = ordy;
        sync_clear = sc;
        #1 chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".ov"}, 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk({tag, ".ob"}, 32'(out_bit), 32'(exp_ob));
            chk({tag, ".os"}, 32'(out_stuffed), 32'(exp_os));
        end
    endtask

    // Offer one bit and wait (bounded) until it is taken.
    task automatic push(input logic b);
        in_valid   = 1'b1;
        in_bit     = b;
        out_ready  = 1'b1;
        sync_clear = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (in_ready) break;
            @(posedge clk);
            #1;
        end
        chk("push.rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b0;
        sync_clear = 1'b0;

        // reset state
        #3;
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.ob", 32'(out_bit), 32'd0);
        chk("rst.os", 32'(out_stuffed), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        chk("rst.cnt", 32'(stuff_count), 32'd0);
        chk("rst.state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // T1: 0,0,0,0,1 -> 0,0,0,0,1s,1
        step("t1.d0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t1.d1", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t1.d2", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t1.d3", 1, 0, 1, 0, 1, 1, 0, 0);
        chk("t1.pend", 32'(dbg_pending), 32'd1);
        step("t1.stf", 1, 1, 1, 0, 0, 1, 1, 1);
        chk("t1.cnt", 32'(stuff_count), 32'd1);
        chk("t1.state", 32'(dbg_state), 32'd2);
        step("t1.d4", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t1.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t1.cnt2", 32'(stuff_count), 32'd1);
        step("t1.clr", 0, 0, 1, 1, 0, 0, 0, 0);

        // T2: eight 1s -> 1,1,1,1,0s,1,1,1,1,0s
        step("t2.a0", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.a1", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.a2", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.a3", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.s0", 1, 1, 1, 0, 0, 1, 0, 1);
        step("t2.b0", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.b1", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.b2", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.b3", 1, 1, 1, 0, 1, 1, 1, 0);
        step("t2.s1", 0, 0, 1, 0, 0, 1, 0, 1);
        step("t2.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t2.cnt", 32'(stuff_count), 32'd3);
        step("t2.clr", 0, 0, 1, 1, 0, 0, 0, 0);

        // T3: backpressure while a stuff bit is on the line
        step("t3.d0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t3.d1", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t3.d2", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t3.d3", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t3.stf", 1, 1, 1, 0, 0, 1, 1, 1);
        step("t3.h0", 1, 1, 0, 0, 0, 1, 1, 1);
        step("t3.h1", 1, 1, 0, 0, 0, 1, 1, 1);
        step("t3.h2", 1, 1, 0, 0, 0, 1, 1, 1);
        chk("t3.run", 32'(dbg_run_len), 32'd1);
        chk("t3.pend", 32'(dbg_pending), 32'd0);
        chk("t3.cnt", 32'(stuff_count), 32'd4);
        step("t3.res", 1, 1, 1, 0, 1, 1, 1, 0);
        chk("t3.run2", 32'(dbg_run_len), 32'd2);
        step("t3.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        step("t3.clr", 0, 0, 1, 1, 0, 0, 0, 0);

        // T4: run survives an idle gap
        step("t4.d0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t4.d1", 1, 0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("t4.gap", 0, 0, 1, 0, 1, 0, 0, 0);
        step("t4.d2", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t4.d3", 1, 0, 1, 0, 1, 1, 0, 0);
        chk("t4.pend", 32'(dbg_pending), 32'd1);
        step("t4.stf", 0, 0, 1, 0, 0, 1, 1, 1);
        step("t4.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t4.cnt", 32'(stuff_count), 32'd5);
        step("t4.clr", 0, 0, 1, 1, 0, 0, 0, 0);

        // T5: sync_clear right after the 4th 0 drops the owed stuff bit
        step("t5.d0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t5.d1", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t5.d2", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t5.d3", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t5.clr", 1, 0, 1, 1, 0, 0, 0, 0);
        chk("t5.pend", 32'(dbg_pending), 32'd0);
        chk("t5.run0", 32'(dbg_run_len), 32'd0);
        step("t5.d4", 1, 0, 1, 0, 1, 1, 0, 0);
        chk("t5.run1", 32'(dbg_run_len), 32'd1);
        chk("t5.cnt", 32'(stuff_count), 32'd5);

        // T6: reset mid-run with a stuff bit owed
        step("t6.d0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t6.d1", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t6.d2", 1, 0, 1, 0, 1, 1, 0, 0);
        chk("t6.pend", 32'(dbg_pending), 32'd1);
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("t6.ov", 32'(out_valid), 32'd0);
        chk("t6.ob", 32'(out_bit), 32'd0);
        chk("t6.os", 32'(out_stuffed), 32'd0);
        chk("t6.rdy", 32'(in_ready), 32'd0);
        chk("t6.cnt", 32'(stuff_count), 32'd0);
        chk("t6.pend0", 32'(dbg_pending), 32'd0);
        chk("t6.run0", 32'(dbg_run_len), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6.held", 32'(out_valid), 32'd0);
        reset = 1'b1;
        step("t6.e0", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t6.e1", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t6.e2", 1, 0, 1, 0, 1, 1, 0, 0);
        step("t6.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t6.cnt2", 32'(stuff_count), 32'd0);
        chk("t6.pend1", 32'(dbg_pending), 32'd0);
        step("t6.clr", 0, 0, 1, 1, 0, 0, 0, 0);

        // T7: 40 ones -> 10 stuff bits; a 3-bit counter must stop at 7
        for (int i = 0; i < 40; i++) push(1'b1);
        step("t7.drain", 0, 0, 1, 0, 0, 1, 0, 1);
        step("t7.idle", 0, 0, 1, 0, 1, 0, 0, 0);
        chk("t7.cnt", 32'(stuff_count), 32'd7);

        // line never carried more than MAX_RUN equal bits
        chk("mon.maxrun", 32'(mon_max <= MAX_RUN), 32'd1);
        chk("mon.seen", 32'(mon_max == MAX_RUN), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_limit_stuffer.md
RUN_LIMIT_STUFFER -- requirements
Module: run_limit_stuffer

Interface
REQ-001 The block SHALL have parameter MAX_RUN, default 4, meaning the longest run of equal consecutive output bits before a stuff bit is forced (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stuff-event counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream data bit valid.
REQ-006 in_bit  input  1  upstream data bit.
REQ-007 in_ready  output  1  block accepts in_bit this cycle.
REQ-008 out_valid  output  1  out_bit valid.
REQ-009 out_bit  output  1  serial line bit, the input to the run-length detector.
REQ-010 out_ready  input  1  downstream consumes out_bit this cycle.
REQ-011 out_stuffed  output  1  current out_bit is an inserted stuff bit, not data.
REQ-012 sync_clear  input  1  synchronous start-of-frame; clears run tracking.
REQ-013 stuff_count  output  CNT_W  saturating count of inserted stuff bits.

Function
REQ-014 Handshakes SHALL follow valid/ready rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
REQ-015 Output register SHALL be "loadable" when out_valid==0 or out_ready==1.
REQ-016 in_ready SHALL equal loadable & ~pending_stuff & ~sync_clear (combinational from out_ready).
REQ-017 Tracking state SHALL be last_bit (1 bit), run_len (0..MAX_RUN), pending_stuff (1 bit).
REQ-018 FSM states SHALL be EMPTY (out_valid=0), DATA (holding data bit), STUFF (holding stuff bit); pending_stuff is orthogonal to these.
REQ-019 When loadable and pending_stuff: load out_bit=~last_bit, out_stuffed=1, last_bit<=~last_bit, run_len<=1, pending_stuff<=0, go to STUFF, stuff_count+1.
REQ-020 When loadable, no pending_stuff, input transfer: load out_bit=in_bit, out_stuffed=0, go to DATA; run_len<=run_len+1 if run_len!=0 and in_bit==last_bit, else 1; last_bit<=in_bit.
REQ-021 If the updated run_len equals MAX_RUN, pending_stuff SHALL be set in the same cycle.
REQ-022 When loadable and nothing to load: out_valid<=0, state EMPTY; tracking unchanged.
REQ-023 When not loadable: out_bit, out_stuffed, out_valid SHALL hold; no tracking update.
REQ-024 Latency SHALL be one cycle: bit accepted in cycle N is out_valid in cycle N+1 (stuff bit occupies the following slot).
REQ-025 Run tracking SHALL persist across idle gaps; runs are counted in the bit stream, not in time.
REQ-026 A stuff bit SHALL start a new run of length 1 that subsequent equal data bits extend.
REQ-027 Output stream SHALL never contain more than MAX_RUN equal consecutive bits; every run of exactly MAX_RUN data bits is followed by a stuff bit.
REQ-028 sync_clear SHALL take priority over load: run_len<=0, pending_stuff<=0 (pending stuff discarded), no input accepted; output register still drains normally (out_valid<=0 if loadable).
REQ-029 stuff_count SHALL saturate at all-ones and not wrap.

Reset
REQ-030 On reset low: out_valid=0, out_bit=0, out_stuffed=0, state EMPTY, run_len=0, last_bit=0, pending_stuff=0, stuff_count=0, immediately and asynchronously.
REQ-031 in_ready SHALL be 0 while reset is low; reset mid-frame discards the output register and any pending stuff without emitting it.

Verification
REQ-032 out_ready=1, input 0,0,0,0,1 back-to-back -> out_bit 0,0,0,0,1(out_stuffed=1),1; in_ready=0 for exactly one cycle after 4th 0 accepted; stuff_count=1.
REQ-033 Input eight 1s, out_ready=1 -> out_bit 1,1,1,1,0s,1,1,1,1,0s; stuff_count=2; detector on output never sees 5 equal bits.
REQ-034 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_bit/out_stuffed stable, in_ready=0, no tracking change; resumes correctly.
REQ-035 Input 0,0, idle 5 cycles, 0,0 -> stuff 1 after 4th 0 (run survives gap).
REQ-036 Input 0,0,0,0 then sync_clear in the cycle after the 4th is accepted -> no stuff bit emitted; next data 0 starts run_len=1.
REQ-037 Assert reset low mid-run with pending_stuff=1 -> all outputs zero at once; after release, 0,0,0 input produces no stuff.
